// File: rtl/program_sequencer.sv
// Instruction sequencer: fetches from sync imem and holds run until cu_done; 7 cycles/instr with a 4-cycle CU.
// Backpressure: the control unit stalls via cu_done; stop/step/halt only act on instruction boundaries.
module program_sequencer #(
    parameter int          AW       = 4,
    parameter int          PROG_LEN = 16,
    parameter logic [15:0] HALT_OP  = 16'hFFFF,
    parameter bit          WRAP     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          step_mode,
    input  logic          step,
    output logic [AW-1:0] imem_addr,
    output logic          imem_rd,
    input  logic [15:0]   imem_data,
    output logic [15:0]   instr,
    output logic          run,
    input  logic          cu_done,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic [15:0]   instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_NEXT,
        S_PAUSE,
        S_HALTED
    } state_t;

    localparam logic [AW-1:0] LAST_PC = AW'(PROG_LEN - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   instr_q, instr_d;
    logic          run_q, run_d;
    logic [15:0]   count_q, count_d;
    logic          stop_pending_q, stop_pending_d;
    logic          stop_now;
    logic          at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            instr_q        <= '0;
            run_q          <= 1'b0;
            count_q        <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            run_q          <= run_d;
            count_q        <= count_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        run_d          = 1'b0;
        count_d        = count_q;
        stop_pending_d = stop_pending_q;
        // a stop arriving in NEXT takes effect at this boundary, not the following one
        stop_now       = stop_pending_q | stop;
        at_last        = (pc_q == LAST_PC);

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d           = '0;
                    count_d        = '0;
                    stop_pending_d = 1'b0;
                    state_d        = S_FETCH;
                end
            end
            S_FETCH: begin
                stop_pending_d = stop_now;
                state_d        = S_LATCH;
            end
            S_LATCH: begin
                stop_pending_d = stop_now;
                instr_d        = imem_data;
                if (imem_data == HALT_OP) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                    run_d   = 1'b1;
                end
            end
            S_EXEC: begin
                stop_pending_d = stop_now;
                if (cu_done && run_q) begin
                    state_d = S_NEXT;
                end else begin
                    run_d = 1'b1;
                end
            end
            S_NEXT: begin
                stop_pending_d = stop_now;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
                if (at_last) begin
                    if (WRAP) begin
                        pc_d = '0;
                    end
                end else begin
                    pc_d = pc_q + AW'(1);
                end
                if (at_last && !WRAP) begin
                    state_d = S_HALTED;
                end else if (stop_now) begin
                    state_d        = S_IDLE;
                    stop_pending_d = 1'b0;
                end else if (step_mode) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d        = S_IDLE;
                    stop_pending_d = 1'b0;
                end else if (step) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_rd     = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign run         = run_q;
    assign instr_count = count_q;
    assign halted      = (state_q == S_HALTED);
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: DUT a (PROG_LEN=4, WRAP=0) and DUT b (PROG_LEN=4, WRAP=1),
// each with a behavioural sync memory and a 4-cycle control unit that raises done in its S3.
module tb_program_sequencer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, stop = 1'b0, step_mode = 1'b0, step = 1'b0, start_b = 1'b0;

    logic [AW-1:0] imem_addr_a, pc_a, imem_addr_b, pc_b;
    logic          imem_rd_a, run_a, cu_done_a, busy_a, halted_a;
    logic          imem_rd_b, run_b, cu_done_b, busy_b, halted_b;
    logic [15:0]   imem_data_a = 16'h0, imem_data_b = 16'h0;
    logic [15:0]   instr_a, count_a, instr_b, count_b;
    logic [1:0]    cu_cnt_a, cu_cnt_b;
    logic [15:0]   mem [0:15];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_sequencer #(.AW(AW), .PROG_LEN(4), .HALT_OP(16'hFFFF), .WRAP(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode), .step(step),
        .imem_addr(imem_addr_a), .imem_rd(imem_rd_a), .imem_data(imem_data_a),
        .instr(instr_a), .run(run_a), .cu_done(cu_done_a), .pc(pc_a),
        .busy(busy_a), .halted(halted_a), .instr_count(count_a)
    );

    program_sequencer #(.AW(AW), .PROG_LEN(4), .HALT_OP(16'hFFFF), .WRAP(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(1'b0), .step_mode(1'b0), .step(1'b0),
        .imem_addr(imem_addr_b), .imem_rd(imem_rd_b), .imem_data(imem_data_b),
        .instr(instr_b), .run(run_b), .cu_done(cu_done_b), .pc(pc_b),
        .busy(busy_b), .halted(halted_b), .instr_count(count_b)
    );

    always @(posedge clk) begin
        if (imem_rd_a) imem_data_a <= mem[imem_addr_a];
        if (imem_rd_b) imem_data_b <= mem[imem_addr_b];
    end

    // control unit: S0..S3 while run is high, done in S3, back to S0 on the done edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cu_cnt_a <= 2'd0;
            cu_cnt_b <= 2'd0;
        end else begin
            cu_cnt_a <= run_a ? cu_cnt_a + 2'd1 : 2'd0;
            cu_cnt_b <= run_b ? cu_cnt_b + 2'd1 : 2'd0;
        end
    end
    assign cu_done_a = run_a && (cu_cnt_a == 2'd3);
    assign cu_done_b = run_b && (cu_cnt_b == 2'd3);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; step_mode = 1'b0; start_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if ({imem_rd_a, run_a, busy_a, halted_a} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: got %b exp 0000", {imem_rd_a, run_a, busy_a, halted_a}); end
        checks++; if ({pc_a, imem_addr_a} !== 8'h00) begin errors++;
            $display("FAIL reset_pc: got %h exp 00", {pc_a, imem_addr_a}); end
        checks++; if ({instr_a, count_a} !== 32'h0) begin errors++;
            $display("FAIL reset_instr_count: got %h exp 00000000", {instr_a, count_a}); end
        rst = 1'b0;
        tick();
        stop = 1'b1; step = 1'b1;
        tick();
        stop = 1'b0; step = 1'b0;
        tick();
        tick();
        checks++; if ({busy_a, imem_rd_a, halted_a} !== 3'b000) begin errors++;
            $display("FAIL idle_ignores_stop_step: got %b exp 000", {busy_a, imem_rd_a, halted_a}); end
    endtask

    task automatic test_halt_program();
        int n, run1, run2, bad;
        n = 0; run1 = 0; run2 = 0; bad = 0;
        load_prog(16'h2408, 16'h4C10, 16'hFFFF, 16'h1111);
        do_reset();
        start = 1'b1;
        checks++; if (imem_rd_a !== 1'b0) begin errors++;
            $display("FAIL no_fetch_before_start: got %b exp 0", imem_rd_a); end
        tick();
        start = 1'b0;
        checks++; if ({imem_rd_a, imem_addr_a} !== {1'b1, 4'd0}) begin errors++;
            $display("FAIL first_fetch: got rd=%b addr=%h exp rd=1 addr=0", imem_rd_a, imem_addr_a); end
        while (!halted_a && n < 60) begin
            if (run_a && instr_a == 16'h2408) run1++;
            if (run_a && instr_a == 16'h4C10) run2++;
            if (run_a && instr_a == 16'hFFFF) bad++;
            tick();
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL halt_latency: got %0d exp 16", n); end
        checks++; if (run1 != 4) begin errors++; $display("FAIL run_cycles_2408: got %0d exp 4", run1); end
        checks++; if (run2 != 4) begin errors++; $display("FAIL run_cycles_4c10: got %0d exp 4", run2); end
        checks++; if (bad != 0) begin errors++; $display("FAIL run_on_halt_op: got %0d exp 0", bad); end
        checks++; if ({halted_a, busy_a, run_a, pc_a} !== {3'b100, 4'd2}) begin errors++;
            $display("FAIL halted_state: got h=%b b=%b r=%b pc=%h exp 1 0 0 2", halted_a, busy_a, run_a, pc_a); end
        checks++; if ({instr_a, count_a} !== {16'hFFFF, 16'd2}) begin errors++;
            $display("FAIL halted_instr_count: got %h %0d exp ffff 2", instr_a, count_a); end
    endtask

    task automatic test_prog_end();
        int n, fetches;
        logic [AW-1:0] addrs [5];
        logic [AW-1:0] exp_addr [5];
        exp_addr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        addrs = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        load_prog(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (27) tick();
        checks++; if ({halted_a, busy_a} !== 2'b01) begin errors++;
            $display("FAIL end_not_early: got h=%b b=%b exp 0 1", halted_a, busy_a); end
        tick();
        checks++; if ({halted_a, busy_a, pc_a} !== {2'b10, 4'd3}) begin errors++;
            $display("FAIL end_halted: got h=%b b=%b pc=%h exp 1 0 3", halted_a, busy_a, pc_a); end
        checks++; if (count_a !== 16'd4) begin errors++;
            $display("FAIL end_count: got %0d exp 4", count_a); end

        do_reset();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0; fetches = 0;
        while (fetches < 5 && n < 80) begin
            if (imem_rd_b) begin
                addrs[fetches] = imem_addr_b;
                fetches++;
            end
            tick();
            n++;
        end
        checks++; if (fetches != 5) begin errors++; $display("FAIL wrap_fetch_count: got %0d exp 5", fetches); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (addrs[i] !== exp_addr[i]) begin errors++;
                $display("FAIL wrap_fetch_addr%0d: got %h exp %h", i, addrs[i], exp_addr[i]); end
        end
        checks++; if ({halted_b, busy_b} !== 2'b01) begin errors++;
            $display("FAIL wrap_still_running: got h=%b b=%b exp 0 1", halted_b, busy_b); end
    endtask

    task automatic test_step();
        load_prog(16'h2408, 16'h4C10, 16'h0001, 16'h0002);
        do_reset();
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) step_mode = 1'b0;
            checks++; if ({busy_a, run_a, imem_rd_a, pc_a} !== {3'b100, 4'd1}) begin errors++;
                $display("FAIL pause_hold_%0d: got b=%b r=%b rd=%b pc=%h exp 1 0 0 1", i, busy_a, run_a, imem_rd_a, pc_a); end
            tick();
        end
        checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL pause_count: got %0d exp 1", count_a); end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if ({imem_rd_a, imem_addr_a} !== {1'b1, 4'd1}) begin errors++;
            $display("FAIL step_fetch: got rd=%b addr=%h exp rd=1 addr=1", imem_rd_a, imem_addr_a); end
    endtask

    task automatic test_stop();
        load_prog(16'h2408, 16'h4C10, 16'h0001, 16'h0002);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL exec_c2_run: got %b exp 1", run_a); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL stop_no_abort_c3: got %b exp 1", run_a); end
        tick();
        checks++; if ({run_a, cu_done_a} !== 2'b11) begin errors++;
            $display("FAIL stop_no_abort_c4: got run=%b done=%b exp 1 1", run_a, cu_done_a); end
        tick();
        checks++; if ({run_a, busy_a} !== 2'b01) begin errors++;
            $display("FAIL stop_next: got run=%b busy=%b exp 0 1", run_a, busy_a); end
        tick();
        checks++; if ({busy_a, halted_a, pc_a} !== {2'b00, 4'd1}) begin errors++;
            $display("FAIL stop_idle: got b=%b h=%b pc=%h exp 0 0 1", busy_a, halted_a, pc_a); end
        checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL stop_count: got %0d exp 1", count_a); end
        repeat (5) tick();
        checks++; if ({busy_a, imem_rd_a} !== 2'b00) begin errors++;
            $display("FAIL stop_stays_idle: got b=%b rd=%b exp 0 0", busy_a, imem_rd_a); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({imem_rd_a, imem_addr_a, count_a} !== {1'b1, 4'd0, 16'd0}) begin errors++;
            $display("FAIL restart_after_stop: got rd=%b pc=%h cnt=%0d exp 1 0 0", imem_rd_a, imem_addr_a, count_a); end
    endtask

    task automatic test_reset_exec();
        int bad;
        bad = 0;
        load_prog(16'h2408, 16'h4C10, 16'h0001, 16'h0002);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checks++; if ({run_a, pc_a, instr_a, count_a} !== {1'b1, 4'd1, 16'h4C10, 16'd1}) begin errors++;
            $display("FAIL pre_reset_exec: got run=%b pc=%h instr=%h cnt=%0d exp 1 1 4c10 1", run_a, pc_a, instr_a, count_a); end
        rst = 1'b1;
        #2;
        checks++; if ({run_a, busy_a, imem_rd_a, pc_a} !== {3'b000, 4'd0}) begin errors++;
            $display("FAIL async_reset_ctl: got run=%b b=%b rd=%b pc=%h exp 0 0 0 0", run_a, busy_a, imem_rd_a, pc_a); end
        checks++; if ({instr_a, count_a} !== 32'h0) begin errors++;
            $display("FAIL async_reset_data: got %h %0d exp 0000 0", instr_a, count_a); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy_a || imem_rd_a || run_a) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL post_reset_idle: got %0d active cycles exp 0", bad); end
    endtask

    task automatic test_start_stop_halted();
        int n, idle_seen;
        n = 0; idle_seen = 0;
        load_prog(16'h2408, 16'h4C10, 16'hFFFF, 16'h0000);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!halted_a && n < 60) begin tick(); n++; end
        checks++; if (halted_a !== 1'b1) begin errors++; $display("FAIL reach_halted: got %b exp 1", halted_a); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++; if ({imem_rd_a, imem_addr_a, busy_a} !== {1'b1, 4'd0, 1'b1}) begin errors++;
            $display("FAIL start_stop_restart: got rd=%b addr=%h b=%b exp 1 0 1", imem_rd_a, imem_addr_a, busy_a); end
        n = 0;
        while (!halted_a && n < 60) begin
            if (!busy_a && !halted_a) idle_seen++;
            tick();
            n++;
        end
        checks++; if (idle_seen != 0) begin errors++; $display("FAIL start_stop_no_idle: got %0d idle cycles exp 0", idle_seen); end
        checks++; if (n != 16) begin errors++; $display("FAIL start_stop_run_length: got %0d exp 16", n); end
        checks++; if ({halted_a, pc_a, count_a} !== {1'b1, 4'd2, 16'd2}) begin errors++;
            $display("FAIL start_stop_final: got h=%b pc=%h cnt=%0d exp 1 2 2", halted_a, pc_a, count_a); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        test_reset();
        test_halt_program();
        test_prog_end();
        test_step();
        test_stop();
        test_reset_exec();
        test_start_stop_halted();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
